// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - length-prefixed byte-stream loader that fills instruction memory and raises start_o.
// Optional trailing XOR checksum with CHECK/ERROR states when BOOT_CHECKSUM_EN is defined.
module imem_boot_loader #(
   parameter int IMEM_WORDS = 256,
   parameter int ADDR_W     = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [7:0]        data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_data_o,
   output logic              start_o,
   output logic              error_o,
   output logic [ADDR_W:0]   words_o
);

   localparam int CW = ADDR_W + 1;

   typedef enum logic [2:0] {
      S_RST,
      S_IDLE,
      S_LOAD,
`ifdef BOOT_CHECKSUM_EN
      S_CHECK,
      S_ERROR,
`endif
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     n_q, n_d;
   logic [23:0]       shift_q, shift_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic              start_q, start_d;
   logic              accept;
   logic [CW-1:0]     hdr_n;
   logic [CW-1:0]     cnt_inc;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
   logic              error_q, error_d;
`endif

   // S_RST keeps ready_o low until the first edge after reset release.
   always_comb begin
      ready_o = 1'b0;
      case (state_q)
         S_IDLE, S_LOAD: ready_o = 1'b1;
`ifdef BOOT_CHECKSUM_EN
         S_CHECK:        ready_o = 1'b1;
`endif
         default:        ready_o = 1'b0;
      endcase
   end

   assign accept  = valid_i && ready_o;
   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      hdr_n = CW'(data_i) + CW'(1);
      if (hdr_n > CW'(IMEM_WORDS)) begin
         hdr_n = CW'(IMEM_WORDS);
      end
   end

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      shift_d = shift_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      start_d = (state_q == S_DONE);
`ifdef BOOT_CHECKSUM_EN
      csum_d  = csum_q;
      error_d = error_q;
`endif
      case (state_q)
         S_RST: state_d = S_IDLE;
         S_IDLE: begin
            if (accept) begin
               n_d     = hdr_n;
               lane_d  = 2'd0;
               cnt_d   = '0;
               state_d = S_LOAD;
`ifdef BOOT_CHECKSUM_EN
               csum_d  = data_i;
`endif
            end
         end
         S_LOAD: begin
            if (accept) begin
               lane_d = lane_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
               csum_d = csum_q ^ data_i;
`endif
               case (lane_q)
                  2'd0: shift_d[7:0]   = data_i;
                  2'd1: shift_d[15:8]  = data_i;
                  2'd2: shift_d[23:16] = data_i;
                  default: begin
                     we_d   = 1'b1;
                     addr_d = cnt_q[ADDR_W-1:0];
                     data_d = {data_i, shift_q};
                     cnt_d  = cnt_inc;
                     if (cnt_inc == n_q) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                     end
                  end
               endcase
            end
         end
`ifdef BOOT_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               if (data_i == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
         S_ERROR: state_d = S_ERROR;
`endif
         S_DONE: state_d = S_DONE;
         default: state_d = S_RST;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_RST;
         lane_q  <= 2'd0;
         cnt_q   <= '0;
         n_q     <= '0;
         shift_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum_q  <= '0;
         error_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         start_q <= start_d;
`ifdef BOOT_CHECKSUM_EN
         csum_q  <= csum_d;
         error_q <= error_d;
`endif
      end
   end

   assign imem_we_o   = we_q;
   assign imem_addr_o = addr_q;
   assign imem_data_o = data_q;
   assign start_o     = start_q;
   assign words_o     = cnt_q;
`ifdef BOOT_CHECKSUM_EN
   assign error_o     = error_q;
`else
   assign error_o     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed and randomized loads checked against a byte-image reference model.
module tb_imem_boot_loader;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [7:0]  data_i = 8'h00;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic        imem_we_o;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_data_o;
   logic        start_o;
   logic        error_o;
   logic [8:0]  words_o;

   int checks = 0;
   int failures = 0;

   logic [7:0]  sb_addr[$];
   logic [31:0] sb_data[$];

   imem_boot_loader #(.IMEM_WORDS(256), .ADDR_W(8)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .data_i(data_i), .valid_i(valid_i),
      .ready_o(ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
      .imem_data_o(imem_data_o), .start_o(start_o), .error_o(error_o), .words_o(words_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (rst_n_i && imem_we_o) begin
         sb_addr.push_back(imem_addr_o);
         sb_data.push_back(imem_data_o);
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Little-endian word i of the payload image.
   function automatic logic [31:0] word_of(input logic [7:0] pl[$], input int i);
      return 32'(pl[4*i]) + 32'(pl[4*i+1]) * 256 + 32'(pl[4*i+2]) * 65536
             + 32'(pl[4*i+3]) * 16777216;
   endfunction

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk_i);
      data_i  = b;
      valid_i = 1'b1;
      while (!ready_o && t < 100) begin
         @(negedge clk_i);
         t++;
      end
      if (!ready_o) begin
         check("send_ready", 32'(ready_o), 32'd1);
         valid_i = 1'b0;
      end else begin
         @(posedge clk_i);
         #1;
         valid_i = 1'b0;
         data_i  = 8'($urandom);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_n_i = 1'b0;
      valid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
   endtask

   // gap: 0 back-to-back, 1 one idle cycle between bytes, 2 random idle cycles.
   task automatic load(input int h, input logic [7:0] pl[$], input int gap, input bit bad);
      int n;
      logic [7:0] cs;
      n  = h + 1;
      cs = 8'(h);
      sb_addr.delete();
      sb_data.delete();
      send(8'(h));
      for (int i = 0; i < pl.size(); i++) begin
         if (i > 0) begin
            if (gap == 1) @(negedge clk_i);
            else if (gap == 2) repeat ($urandom_range(0, 2)) @(negedge clk_i);
         end
         cs = cs ^ pl[i];
         send(pl[i]);
      end
      @(negedge clk_i);
      check("last_we", 32'(imem_we_o), 32'd1);
      check("last_addr", 32'(imem_addr_o), 32'(n - 1));
      check("last_data", imem_data_o, word_of(pl, n - 1));
      check("words", 32'(words_o), 32'(n));
      check("start_early", 32'(start_o), 32'd0);
`ifdef BOOT_CHECKSUM_EN
      send(cs ^ {7'd0, bad});
      @(negedge clk_i);
      check("error_edge", 32'(error_o), 32'(bad));
      check("start_before_done", 32'(start_o), 32'd0);
`endif
      @(negedge clk_i);
      check("start", 32'(start_o), bad ? 32'd0 : 32'd1);
      check("ready_end", 32'(ready_o), 32'd0);
      check("error_end", 32'(error_o), 32'(bad));
      check("strobe_count", 32'(sb_addr.size()), 32'(n));
      for (int i = 0; i < n && i < sb_addr.size(); i++) begin
         check("sb_addr", 32'(sb_addr[i]), 32'(i));
         check("sb_data", sb_data[i], word_of(pl, i));
      end
   endtask

   initial begin
      logic [7:0] pl[$];
      int h;

      #1;
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_we", 32'(imem_we_o), 32'd0);
      check("rst_addr", 32'(imem_addr_o), 32'd0);
      check("rst_data", imem_data_o, 32'd0);
      check("rst_start", 32'(start_o), 32'd0);
      check("rst_error", 32'(error_o), 32'd0);
      check("rst_words", 32'(words_o), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      check("ready_before_edge", 32'(ready_o), 32'd0);
      @(negedge clk_i);
      check("ready_after_edge", 32'(ready_o), 32'd1);

      pl = '{8'h13, 8'h00, 8'h50, 8'h00};
      load(0, pl, 0, 1'b0);
      if (sb_data.size() > 0) check("t1_word", sb_data[0], 32'h00500013);

      do_reset();
      pl.delete();
      for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
      load(2, pl, 1, 1'b0);

      do_reset();
      pl.delete();
      for (int k = 0; k < 1024; k++) pl.push_back(8'(k % 256));
      load(255, pl, 0, 1'b0);
      if (sb_data.size() == 256) check("t3_last", sb_data[255], 32'hFFFEFDFC);

      @(negedge clk_i);
      data_i  = 8'hAA;
      valid_i = 1'b1;
      repeat (6) begin
         @(negedge clk_i);
         data_i = 8'($urandom);
      end
      check("done_ready", 32'(ready_o), 32'd0);
      check("done_strobes", 32'(sb_addr.size()), 32'd256);
      check("done_words", 32'(words_o), 32'd256);
      check("done_start", 32'(start_o), 32'd1);
      valid_i = 1'b0;

      for (int r = 0; r < 4; r++) begin
         do_reset();
         h = $urandom_range(0, 7);
         pl.delete();
         for (int i = 0; i < 4 * (h + 1); i++) pl.push_back(8'($urandom));
         load(h, pl, 2, 1'b0);
      end

`ifdef BOOT_CHECKSUM_EN
      do_reset();
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      load(0, pl, 0, 1'b1);
      repeat (3) @(negedge clk_i);
      check("err_hold", 32'(error_o), 32'd1);
      check("err_start", 32'(start_o), 32'd0);
      check("err_ready", 32'(ready_o), 32'd0);
`endif

      do_reset();
      send(8'h03);
      for (int i = 0; i < 6; i++) send(8'($urandom_range(1, 255)));
      @(negedge clk_i);
      check("mid_words", 32'(words_o), 32'd1);
      #2;
      rst_n_i = 1'b0;
      #1;
      check("abort_ready", 32'(ready_o), 32'd0);
      check("abort_we", 32'(imem_we_o), 32'd0);
      check("abort_addr", 32'(imem_addr_o), 32'd0);
      check("abort_data", imem_data_o, 32'd0);
      check("abort_start", 32'(start_o), 32'd0);
      check("abort_error", 32'(error_o), 32'd0);
      check("abort_words", 32'(words_o), 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      pl.delete();
      for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
      load(0, pl, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
